nand_async_seq: RTL and testbench
=================================

# nand_async_seq

Asynchronous-mode (ONFI SDR) NAND bus sequencer sitting directly upstream of the NAND PHY. Accepts one byte-level request at a time (command, address, write-data or read-data cycle). Drives the PHY's controller-facing pins with programmable WE#/RE# pulse timing: CE#, CLE, ALE, WE# via the PHY's WE#/clock ODDR path, RE# via the W/R# pin, DQ output enable and write data. Returns read bytes sampled from the PHY's combinational read path.

## Interface
- DQ_WIDTH, 8: data byte width.
- T_SETUP, 2: cycles of CE#/CLE/ALE/DQ setup before the WE# or RE# pulse (1..15).
- T_WP, 3: WE# low cycles (1..15).
- T_WH, 2: WE# high/hold cycles after the rising edge (1..15).
- T_RP, 3: RE# low cycles (1..15).
- T_REH, 2: RE# high cycles after the RE# rising edge (1..15).

Ports:
- v_clk0  in  1  sole clock (PHY clk0 domain).
- v_rst0  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; transfer on valid&&ready.
- req_type  in  2  00 CMD, 01 ADDR, 10 WRITE, 11 READ.
- req_data  in  DQ_WIDTH  byte for CMD/ADDR/WRITE; ignored for READ.
- req_chip  in  1  target die: 0 → cen[0], 1 → cen[1].
- req_last  in  1  release CE# after this cycle.
- cfg_wp_n  in  1  write-protect level forwarded to ctrl_wpn.
- rsp_valid  out  1  one-cycle pulse with read byte.
- rsp_data  out  DQ_WIDTH  read byte; holds until next rsp_valid.
- busy  out  1  ~req_ready or any CE# low.
- v_ctrl_cle, v_ctrl_ale  out  1  command/address latch enables.
- v_ctrl_wrn  out  1  RE# (async mode).
- v_ctrl_wpn  out  1  WP#.
- v_ctrl_cen  out  2  CE#, active-low.
- v_ctrl_wen  out  1  WE#.
- v_ctrl_wen_sel  out  1  constant 1 after reset (async WE# path).
- v_dq_data_oe_n  out  1  DQ output enable, active-low.
- v_wr_data_rise, v_wr_data_fall  out  DQ_WIDTH  both equal the driven byte (SDR).
- v_rd_data_comb  in  DQ_WIDTH  unregistered DQ input from PHY.

## Operation
- All outputs registered. Reset values: cle 0, ale 0, wrn 1, wpn 0, cen 2'b11, wen 1, wen_sel 1, oe_n 1, wr data 0, rsp_valid 0, rsp_data 0, req_ready 0 during reset then 1.
- States: IDLE, CE_REL, SETUP, WE_LO, WE_HI, RE_LO, RE_HI, plus a one-cycle END_REL for last.
- IDLE: ready=1. On handshake, request fields are captured. If any CE# is low and req_chip differs from the active die → CE_REL, else → SETUP.
- CE_REL (1 cycle): cen=11, cle/ale 0, oe_n 1; → SETUP.
- SETUP (T_SETUP cycles):
  - Selected CE# low.
  - CLE=1 for CMD; ALE=1 for ADDR.
  - For non-READ: oe_n=0, byte driven.
  - For READ: oe_n=1.
  - → WE_LO (non-READ) or RE_LO (READ).
- WE_LO (T_WP cycles): wen=0, all else held.
- WE_HI (T_WH cycles): wen=1, CLE/ALE/data/oe_n held (hold time).
- RE_LO (T_RP cycles): wrn=0. On the last RE_LO cycle, rd_data_comb is sampled into rsp_data. rsp_valid pulses the following cycle (first RE_HI cycle).
- RE_HI (T_REH cycles): wrn=1.
- After WE_HI/RE_HI:
  - If req_last → END_REL (1 cycle, CE# released, all reset-like) → IDLE.
  - Else → IDLE with CE# still low, cle/ale 0, oe_n 1.
- cfg_wp_n is registered into v_ctrl_wpn every cycle, independent of FSM.
- Phase counter is 4 bits, loaded with (T_x − 1) on phase entry; phase exits at 0.

## Timing
- Handshake at cycle c: outputs reflect SETUP from c+1.
- Non-last write-type request, same die: req_ready returns at c+1+T_SETUP+T_WP+T_WH (defaults: c+8).
- Last write-type request: ready at c+2+T_SETUP+T_WP+T_WH.
- Read request: rsp_valid at c+1+T_SETUP+T_RP (defaults: c+6). Ready at c+1+T_SETUP+T_RP+T_REH (+1 if last).
- Die switch adds 1 cycle (CE_REL).
- req_valid while req_ready=0 is ignored; request fields need be stable only at the handshake cycle.
- WE# and RE# are never low in the same cycle. oe_n is never 0 during RE_LO.
- Reset asserted mid-operation: all outputs go to reset values asynchronously. The in-flight request is dropped and no rsp_valid is produced. First handshake is possible the first cycle after reset deasserts.

## Test plan
- Reset: hold v_rst0, check every output at its reset value. Release and check req_ready=1 next cycle.
- CMD 0x70 chip0, last=0, default timing: cen=10 and cle=1 from c+1, wen=0 exactly at c+3..c+5, data 0x70 with oe_n=0 through c+7, ready at c+8, cen stays 10.
- Sequence CMD 0x00, five ADDR bytes, CMD 0x30 (last) on chip1: ale=1 only during address cycles, single CE# low window, cen=11 at END_REL, five WE# pulses on ALE.
- READ with rd_data_comb=0xA5 during RE_LO: wrn low c+3..c+5, rsp_valid one pulse at c+6 with rsp_data=0xA5, oe_n=1 throughout.
- Die switch: non-last write on chip0 followed by a request on chip1: one cycle cen=11 before cen=01.
- Reset asserted during WE_LO: wen=1, cen=11, oe_n=1 immediately. No rsp_valid. Normal CMD succeeds after release.

Source files
------------

// File: rtl/nand_async_seq.sv
// ONFI SDR asynchronous-mode NAND bus sequencer: one CMD/ADDR/WRITE/READ byte cycle per request, programmable WE#/RE# timing.
// Latency: SETUP from the cycle after handshake, read byte T_SETUP+T_RP cycles later; req_ready is low for the whole bus cycle.
module nand_async_seq #(
    parameter int DQ_WIDTH = 8,
    parameter int T_SETUP  = 2,
    parameter int T_WP     = 3,
    parameter int T_WH     = 2,
    parameter int T_RP     = 3,
    parameter int T_REH    = 2
) (
    input  logic                v_clk0,
    input  logic                v_rst0,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_type,
    input  logic [DQ_WIDTH-1:0] req_data,
    input  logic                req_chip,
    input  logic                req_last,
    input  logic                cfg_wp_n,
    output logic                rsp_valid,
    output logic [DQ_WIDTH-1:0] rsp_data,
    output logic                busy,
    output logic                v_ctrl_cle,
    output logic                v_ctrl_ale,
    output logic                v_ctrl_wrn,
    output logic                v_ctrl_wpn,
    output logic [1:0]          v_ctrl_cen,
    output logic                v_ctrl_wen,
    output logic                v_ctrl_wen_sel,
    output logic                v_dq_data_oe_n,
    output logic [DQ_WIDTH-1:0] v_wr_data_rise,
    output logic [DQ_WIDTH-1:0] v_wr_data_fall,
    input  logic [DQ_WIDTH-1:0] v_rd_data_comb
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CE_REL  = 3'd1;
    localparam logic [2:0] S_SETUP   = 3'd2;
    localparam logic [2:0] S_WE_LO   = 3'd3;
    localparam logic [2:0] S_WE_HI   = 3'd4;
    localparam logic [2:0] S_RE_LO   = 3'd5;
    localparam logic [2:0] S_RE_HI   = 3'd6;
    localparam logic [2:0] S_END_REL = 3'd7;

    localparam logic [1:0] TY_CMD  = 2'b00;
    localparam logic [1:0] TY_ADDR = 2'b01;
    localparam logic [1:0] TY_READ = 2'b11;

    localparam logic [3:0] L_SETUP = 4'(T_SETUP - 1);
    localparam logic [3:0] L_WP    = 4'(T_WP - 1);
    localparam logic [3:0] L_WH    = 4'(T_WH - 1);
    localparam logic [3:0] L_RP    = 4'(T_RP - 1);
    localparam logic [3:0] L_REH   = 4'(T_REH - 1);

    logic [2:0]          r_state;
    logic [3:0]          r_cnt;
    logic [1:0]          r_type;
    logic [DQ_WIDTH-1:0] r_data;
    logic                r_chip;
    logic                r_last;
    logic                r_cle;
    logic                r_ale;
    logic                r_wrn;
    logic                r_wpn;
    logic [1:0]          r_cen;
    logic                r_wen;
    logic                r_wen_sel;
    logic                r_oe_n;
    logic [DQ_WIDTH-1:0] r_wr_data;
    logic                r_rsp_valid;
    logic [DQ_WIDTH-1:0] r_rsp_data;
    logic                r_ready;
    logic                r_busy;

    logic [2:0]          w_state;
    logic [3:0]          w_cnt;
    logic [1:0]          w_type;
    logic [DQ_WIDTH-1:0] w_data;
    logic                w_chip;
    logic                w_last;
    logic                w_cle;
    logic                w_ale;
    logic                w_wrn;
    logic [1:0]          w_cen;
    logic                w_wen;
    logic                w_oe_n;
    logic [DQ_WIDTH-1:0] w_wr_data;
    logic                w_rsp_valid;
    logic [DQ_WIDTH-1:0] w_rsp_data;
    logic                w_ready;
    logic                w_busy;
    logic                w_enter_setup;
    logic                w_release;
    logic                w_park;

    always_comb begin
        w_state       = r_state;
        w_cnt         = (r_cnt != 4'd0) ? r_cnt - 4'd1 : 4'd0;
        w_type        = r_type;
        w_data        = r_data;
        w_chip        = r_chip;
        w_last        = r_last;
        w_cle         = r_cle;
        w_ale         = r_ale;
        w_wrn         = r_wrn;
        w_cen         = r_cen;
        w_wen         = r_wen;
        w_oe_n        = r_oe_n;
        w_wr_data     = r_wr_data;
        w_rsp_valid   = 1'b0;
        w_rsp_data    = r_rsp_data;
        w_enter_setup = 1'b0;
        w_release     = 1'b0;
        w_park        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (req_valid && r_ready) begin
                    w_type = req_type;
                    w_data = req_data;
                    w_chip = req_chip;
                    w_last = req_last;
                    // r_chip still names the die whose CE# is held from the previous request
                    if ((r_cen != 2'b11) && (req_chip != r_chip)) begin
                        w_state   = S_CE_REL;
                        w_release = 1'b1;
                    end else begin
                        w_enter_setup = 1'b1;
                    end
                end
            end
            S_CE_REL: w_enter_setup = 1'b1;
            S_SETUP: begin
                if (r_cnt == 4'd0) begin
                    if (r_type == TY_READ) begin
                        w_state = S_RE_LO;
                        w_wrn   = 1'b0;
                        w_cnt   = L_RP;
                    end else begin
                        w_state = S_WE_LO;
                        w_wen   = 1'b0;
                        w_cnt   = L_WP;
                    end
                end
            end
            S_WE_LO: begin
                if (r_cnt == 4'd0) begin
                    w_state = S_WE_HI;
                    w_wen   = 1'b1;
                    w_cnt   = L_WH;
                end
            end
            S_RE_LO: begin
                if (r_cnt == 4'd0) begin
                    w_state     = S_RE_HI;
                    w_wrn       = 1'b1;
                    w_cnt       = L_REH;
                    w_rsp_valid = 1'b1;
                    w_rsp_data  = v_rd_data_comb;
                end
            end
            S_WE_HI, S_RE_HI: begin
                if (r_cnt == 4'd0) begin
                    if (r_last) begin
                        w_state   = S_END_REL;
                        w_release = 1'b1;
                    end else begin
                        w_state = S_IDLE;
                        w_park  = 1'b1;
                    end
                end
            end
            S_END_REL: w_state = S_IDLE;
            default: begin
                w_state   = S_IDLE;
                w_release = 1'b1;
            end
        endcase

        if (w_enter_setup) begin
            w_state   = S_SETUP;
            w_cnt     = L_SETUP;
            w_cen     = w_chip ? 2'b01 : 2'b10;
            w_cle     = (w_type == TY_CMD);
            w_ale     = (w_type == TY_ADDR);
            w_oe_n    = (w_type == TY_READ);
            w_wr_data = (w_type == TY_READ) ? '0 : w_data;
        end
        if (w_release) begin
            w_cen     = 2'b11;
            w_cle     = 1'b0;
            w_ale     = 1'b0;
            w_oe_n    = 1'b1;
            w_wen     = 1'b1;
            w_wrn     = 1'b1;
            w_wr_data = '0;
        end
        // CE# stays asserted between non-last requests; only the latch enables and DQ drive drop
        if (w_park) begin
            w_cle  = 1'b0;
            w_ale  = 1'b0;
            w_oe_n = 1'b1;
        end
    end

    assign w_ready = (w_state == S_IDLE);
    assign w_busy  = ~w_ready | (w_cen != 2'b11);

    always_ff @(posedge v_clk0 or posedge v_rst0) begin
        if (v_rst0) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_type      <= 2'b00;
            r_data      <= '0;
            r_chip      <= 1'b0;
            r_last      <= 1'b0;
            r_cle       <= 1'b0;
            r_ale       <= 1'b0;
            r_wrn       <= 1'b1;
            r_wpn       <= 1'b0;
            r_cen       <= 2'b11;
            r_wen       <= 1'b1;
            r_wen_sel   <= 1'b1;
            r_oe_n      <= 1'b1;
            r_wr_data   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_type      <= w_type;
            r_data      <= w_data;
            r_chip      <= w_chip;
            r_last      <= w_last;
            r_cle       <= w_cle;
            r_ale       <= w_ale;
            r_wrn       <= w_wrn;
            r_wpn       <= cfg_wp_n;
            r_cen       <= w_cen;
            r_wen       <= w_wen;
            r_wen_sel   <= 1'b1;
            r_oe_n      <= w_oe_n;
            r_wr_data   <= w_wr_data;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_data  <= w_rsp_data;
            r_ready     <= w_ready;
            r_busy      <= w_busy;
        end
    end

    assign req_ready      = r_ready;
    assign busy           = r_busy;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_data       = r_rsp_data;
    assign v_ctrl_cle     = r_cle;
    assign v_ctrl_ale     = r_ale;
    assign v_ctrl_wrn     = r_wrn;
    assign v_ctrl_wpn     = r_wpn;
    assign v_ctrl_cen     = r_cen;
    assign v_ctrl_wen     = r_wen;
    assign v_ctrl_wen_sel = r_wen_sel;
    assign v_dq_data_oe_n = r_oe_n;
    assign v_wr_data_rise = r_wr_data;
    assign v_wr_data_fall = r_wr_data;

endmodule

// File: tb/tb_nand_async_seq.sv
// Directed bench for nand_async_seq: request table checked cycle by cycle plus reset corner cases.
module tb_nand_async_seq;

    localparam int DW   = 8;
    localparam int TS   = 2;
    localparam int TWP  = 3;
    localparam int TWH  = 2;
    localparam int TRP  = 3;
    localparam int TREH = 2;

    logic          v_clk0;
    logic          v_rst0;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_type;
    logic [DW-1:0] req_data;
    logic          req_chip;
    logic          req_last;
    logic          cfg_wp_n;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          busy;
    logic          v_ctrl_cle;
    logic          v_ctrl_ale;
    logic          v_ctrl_wrn;
    logic          v_ctrl_wpn;
    logic [1:0]    v_ctrl_cen;
    logic          v_ctrl_wen;
    logic          v_ctrl_wen_sel;
    logic          v_dq_data_oe_n;
    logic [DW-1:0] v_wr_data_rise;
    logic [DW-1:0] v_wr_data_fall;
    logic [DW-1:0] v_rd_data_comb;

    nand_async_seq #(
        .DQ_WIDTH(DW), .T_SETUP(TS), .T_WP(TWP), .T_WH(TWH), .T_RP(TRP), .T_REH(TREH)
    ) dut (
        .v_clk0(v_clk0), .v_rst0(v_rst0),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_data(req_data), .req_chip(req_chip), .req_last(req_last),
        .cfg_wp_n(cfg_wp_n), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .v_ctrl_cle(v_ctrl_cle), .v_ctrl_ale(v_ctrl_ale), .v_ctrl_wrn(v_ctrl_wrn),
        .v_ctrl_wpn(v_ctrl_wpn), .v_ctrl_cen(v_ctrl_cen), .v_ctrl_wen(v_ctrl_wen),
        .v_ctrl_wen_sel(v_ctrl_wen_sel), .v_dq_data_oe_n(v_dq_data_oe_n),
        .v_wr_data_rise(v_wr_data_rise), .v_wr_data_fall(v_wr_data_fall),
        .v_rd_data_comb(v_rd_data_comb)
    );

    initial v_clk0 = 1'b0;
    always #5 v_clk0 = ~v_clk0;

    typedef struct {
        logic [1:0] typ;
        logic [7:0] data;
        logic       chip;
        logic       last;
        logic [7:0] rd;
        logic       sw;
    } vec_t;

    vec_t vecs[13];
    int   n_tests = 0;
    int   n_fail  = 0;

    // {busy, ready, cen[1:0], cle, ale, wen, wrn, oe_n, rsp_valid}
    logic [9:0] outs;
    assign outs = {busy, req_ready, v_ctrl_cen, v_ctrl_cle, v_ctrl_ale,
                   v_ctrl_wen, v_ctrl_wrn, v_dq_data_oe_n, rsp_valid};

    localparam logic [9:0] RST_OUTS = 10'b1_0_11_0_0_1_1_1_0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected control outputs p cycles after the handshake edge (p=0 is the die-switch cycle)
    function automatic logic [9:0] exp_outs(input vec_t v, input int p);
        logic       rd_t, rdy, cle, ale, wen, wrn, oe, rv;
        logic [1:0] cen, sel;
        int         act_end;
        rd_t    = (v.typ == 2'b11);
        act_end = rd_t ? TS + TRP + TREH : TS + TWP + TWH;
        sel     = v.chip ? 2'b01 : 2'b10;
        rdy = 1'b0; cen = 2'b11; cle = 1'b0; ale = 1'b0;
        wen = 1'b1; wrn = 1'b1; oe = 1'b1; rv = 1'b0;
        if (p >= 1 && p <= act_end) begin
            cen = sel;
            cle = (v.typ == 2'b00);
            ale = (v.typ == 2'b01);
            oe  = rd_t;
            wen = !(!rd_t && p > TS && p <= TS + TWP);
            wrn = !(rd_t && p > TS && p <= TS + TRP);
            rv  = rd_t && (p == TS + TRP + 1);
        end else if (p == act_end + 1) begin
            if (!v.last) begin
                rdy = 1'b1;
                cen = sel;
            end
        end else if (p == act_end + 2) begin
            rdy = 1'b1;
        end
        return {(!rdy || cen != 2'b11), rdy, cen, cle, ale, wen, wrn, oe, rv};
    endfunction

    task automatic run_req(input vec_t v, input int idx);
        int   off, n, act_end, p;
        logic rd_t;
        rd_t    = (v.typ == 2'b11);
        off     = v.sw ? 1 : 0;
        act_end = rd_t ? TS + TRP + TREH : TS + TWP + TWH;
        n       = off + act_end + (v.last ? 2 : 1);
        @(posedge v_clk0); #1;
        req_valid = 1'b1; req_type = v.typ; req_data = v.data;
        req_chip = v.chip; req_last = v.last; v_rd_data_comb = ~v.rd;
        @(posedge v_clk0); #1;
        // keep valid high with junk fields while busy: must be ignored
        req_type = 2'b10; req_data = 8'hEE; req_chip = ~v.chip; req_last = ~v.last;
        for (int k = 1; k <= n; k++) begin
            @(negedge v_clk0);
            p = k - off;
            check($sformatf("v%0d.c%0d ctl", idx, k), 32'(outs), 32'(exp_outs(v, p)));
            if (!rd_t && p >= 1 && p <= act_end)
                check($sformatf("v%0d.c%0d wdata", idx, k),
                      {16'h0, v_wr_data_rise, v_wr_data_fall}, {16'h0, v.data, v.data});
            if (rd_t && p == TS + TRP + 1)
                check($sformatf("v%0d rsp_data", idx), 32'(rsp_data), 32'(v.rd));
            v_rd_data_comb = (p == TS + TRP) ? v.rd : ~v.rd;
            if (k == n - 1) req_valid = 1'b0;
        end
        if (rd_t) check($sformatf("v%0d rsp_hold", idx), 32'(rsp_data), 32'(v.rd));
    endtask

    initial begin
        vecs[0]  = '{2'b00, 8'h70, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{2'b11, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0};
        vecs[2]  = '{2'b00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{2'b01, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[4]  = '{2'b01, 8'h02, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[5]  = '{2'b01, 8'h03, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[6]  = '{2'b01, 8'h04, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[7]  = '{2'b01, 8'h05, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[8]  = '{2'b00, 8'h30, 1'b1, 1'b1, 8'h00, 1'b0};
        vecs[9]  = '{2'b10, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[10] = '{2'b00, 8'h11, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[11] = '{2'b11, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0};
        vecs[12] = '{2'b00, 8'h90, 1'b0, 1'b1, 8'h00, 1'b0};

        v_rst0 = 1'b1; req_valid = 1'b0; req_type = 2'b00; req_data = '0;
        req_chip = 1'b0; req_last = 1'b0; cfg_wp_n = 1'b1; v_rd_data_comb = '0;

        repeat (3) @(negedge v_clk0);
        check("rst ctl", 32'(outs), 32'(RST_OUTS));
        check("rst misc", {7'h0, v_ctrl_wpn, v_ctrl_wen_sel, v_wr_data_rise, v_wr_data_fall, rsp_data},
              {7'h0, 1'b0, 1'b1, 24'h0});
        v_rst0 = 1'b0;
        @(negedge v_clk0);
        check("post-rst ready/busy", {30'h0, req_ready, busy}, 32'h2);
        check("wpn follows cfg", 32'(v_ctrl_wpn), 32'h1);

        for (int i = 0; i < 12; i++) run_req(vecs[i], i);

        // reset in the middle of WE# low
        @(posedge v_clk0); #1;
        req_valid = 1'b1; req_type = 2'b00; req_data = 8'h55; req_chip = 1'b0; req_last = 1'b0;
        @(posedge v_clk0); #1;
        req_valid = 1'b0;
        repeat (TS + 1) @(negedge v_clk0);
        check("pre-rst wen low", 32'(v_ctrl_wen), 32'h0);
        #1 v_rst0 = 1'b1;
        #1 check("mid-rst ctl", 32'(outs), 32'(RST_OUTS));
        for (int k = 0; k < 3; k++) begin
            @(negedge v_clk0);
            check($sformatf("in-rst ctl %0d", k), 32'(outs), 32'(RST_OUTS));
        end
        v_rst0 = 1'b0;
        @(negedge v_clk0);
        check("post-midrst ready", 32'(req_ready), 32'h1);
        run_req(vecs[12], 12);

        cfg_wp_n = 1'b0;
        @(negedge v_clk0);
        check("wpn low", 32'(v_ctrl_wpn), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
